// File: rtl/bcd_alu_seq.sv
// Multi-cycle packed-BCD ALU: add/sub in one compute cycle, digit-serial mul/div.
// Optional input validation is enabled by defining BCD_ALU_SEQ_INPUT_CHECK_EN.
module bcd_alu_seq #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic [4*DIGITS-1:0]     a,
  input  logic [4*DIGITS-1:0]     b,
  output logic                    busy,
  output logic                    done,
  output logic [8*DIGITS-1:0]     result,
  output logic                    status
);

  localparam int unsigned W   = 4 * DIGITS;
  localparam int unsigned W2  = 2 * W;
  localparam int unsigned ND2 = 2 * DIGITS;
  localparam int unsigned DGW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDSUB,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  // Digit-wise decimal add with +6 correction; carry out of the top digit is dropped.
  function automatic logic [W2-1:0] bcd_add(input logic [W2-1:0] x, input logic [W2-1:0] y);
    logic [W2-1:0] s;
    logic [4:0]    t;
    logic          c;
    s = '0;
    c = 1'b0;
    for (int unsigned i = 0; i < ND2; i++) begin
      t = 5'(x[4*i +: 4]) + 5'(y[4*i +: 4]) + 5'(c);
      if (t > 5'd9) begin
        t = t + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i +: 4] = t[3:0];
    end
    return s;
  endfunction

  // Digit-wise decimal subtract x - y (x >= y) with borrow correction.
  function automatic logic [W2-1:0] bcd_sub(input logic [W2-1:0] x, input logic [W2-1:0] y);
    logic [W2-1:0] s;
    logic [4:0]    t;
    logic          br;
    s  = '0;
    br = 1'b0;
    for (int unsigned i = 0; i < ND2; i++) begin
      t = 5'(x[4*i +: 4]) - 5'(y[4*i +: 4]) - 5'(br);
      if (t[4]) begin
        t  = t + 5'd10;
        br = 1'b1;
      end else begin
        br = 1'b0;
      end
      s[4*i +: 4] = t[3:0];
    end
    return s;
  endfunction

`ifdef BCD_ALU_SEQ_INPUT_CHECK_EN
  function automatic logic is_bcd(input logic [W-1:0] x);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction
`endif

  state_t          state_q;
  logic [1:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W2-1:0]   acc_q;
  logic [W+3:0]    rem_q;
  logic [W-1:0]    q_q;
  logic [3:0]      cyc_q;
  logic [DGW-1:0]  dig_q;
  logic            stat_q;
  logic            err_q;

  logic            bad_in_c;
  logic            a_lt_b_c;
  logic [W2-1:0]   sum_c;
  logic [W2-1:0]   diff_c;
  logic [W2-1:0]   mul_add_c;
  logic [W+3:0]    rem_sub_c;
  logic            rem_ge_c;

`ifdef BCD_ALU_SEQ_INPUT_CHECK_EN
  assign bad_in_c = !is_bcd(a) || !is_bcd(b);
`else
  assign bad_in_c = 1'b0;
`endif

  // Packed BCD orders like binary, so magnitude compares need no decoding.
  always_comb begin
    a_lt_b_c  = (a_q < b_q);
    sum_c     = bcd_add(W2'(a_q), W2'(b_q));
    diff_c    = bcd_sub(W2'(a_lt_b_c ? b_q : a_q), W2'(a_lt_b_c ? a_q : b_q));
    mul_add_c = bcd_add(acc_q, W2'(a_q));
    rem_sub_c = (W+4)'(bcd_sub(W2'(rem_q), W2'(b_q)));
    rem_ge_c  = (rem_q >= (W+4)'(b_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cyc_q   <= '0;
      dig_q   <= '0;
      stat_q  <= 1'b0;
      err_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      status  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            rem_q  <= '0;
            q_q    <= '0;
            cyc_q  <= '0;
            dig_q  <= '0;
            stat_q <= 1'b0;
            err_q  <= 1'b0;
            busy   <= 1'b1;
            if (bad_in_c || (op == 2'b11 && b == '0)) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              case (op)
                2'b10:   state_q <= S_MUL;
                2'b11:   state_q <= S_DIV;
                default: state_q <= S_ADDSUB;
              endcase
            end
          end
        end
        S_ADDSUB: begin
          if (op_q[0]) begin
            acc_q  <= diff_c;
            stat_q <= a_lt_b_c;
          end else begin
            acc_q  <= W2'(sum_c[W-1:0]);
            stat_q <= |sum_c[W2-1:W];
          end
          state_q <= S_DONE;
        end
        S_MUL: begin
          // Step 0 of each digit scales by ten; steps 1..digit add A once each.
          if (dig_q == DGW'(DIGITS)) begin
            state_q <= S_DONE;
          end else begin
            if (cyc_q == 4'd0) begin
              acc_q <= acc_q << 4;
            end else if (cyc_q <= b_q[W-1 -: 4]) begin
              acc_q <= mul_add_c;
            end
            if (cyc_q == 4'd9) begin
              cyc_q <= '0;
              dig_q <= dig_q + DGW'(1);
              b_q   <= b_q << 4;
            end else begin
              cyc_q <= cyc_q + 4'd1;
            end
          end
        end
        S_DIV: begin
          // Step 0 brings down the next dividend digit; steps 1..9 are trial subtracts.
          if (dig_q == DGW'(DIGITS)) begin
            state_q <= S_DONE;
          end else begin
            if (cyc_q == 4'd0) begin
              rem_q <= {rem_q[W-1:0], a_q[W-1 -: 4]};
              a_q   <= a_q << 4;
              q_q   <= q_q << 4;
            end else if (rem_ge_c) begin
              rem_q      <= rem_sub_c;
              q_q[3:0]   <= q_q[3:0] + 4'd1;
            end
            if (cyc_q == 4'd9) begin
              cyc_q <= '0;
              dig_q <= dig_q + DGW'(1);
            end else begin
              cyc_q <= cyc_q + 4'd1;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
          if (err_q) begin
            result <= '1;
            status <= 1'b1;
          end else begin
            case (op_q)
              2'b10: begin
                result <= acc_q;
                status <= |acc_q[W2-1:W];
              end
              2'b11: begin
                result <= {rem_q[W-1:0], q_q};
                status <= 1'b0;
              end
              default: begin
                result <= acc_q;
                status <= stat_q;
              end
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Self-checking bench for bcd_alu_seq at DIGITS=2: vector table, random model vectors,
// abort/reset, ignored-start and back-to-back sequences.
module tb_bcd_alu_seq;

  localparam int unsigned DIGITS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        status;

  bcd_alu_seq #(.DIGITS(DIGITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .status (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        st;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        st;
    int          lat;
    bit          chk_val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [7:0] x);
    return int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd8(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] int2bcd16(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Decimal reference model working on plain integers.
  function automatic exp_t model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   ai, bi, v;
    ai = bcd2int(x);
    bi = bcd2int(y);
    e.chk_val = 1'b1;
    e.lat     = 22;
    case (o)
      2'b00: begin
        v = ai + bi;  e.res = int2bcd16(v % 100); e.st = (v >= 100); e.lat = 2;
      end
      2'b01: begin
        v = (ai >= bi) ? ai - bi : bi - ai;
        e.res = int2bcd16(v); e.st = (ai < bi); e.lat = 2;
      end
      2'b10: begin
        v = ai * bi;  e.res = int2bcd16(v); e.st = (v >= 100);
      end
      default: begin
        if (bi == 0) begin
          e.res = 16'hFFFF; e.st = 1'b1; e.lat = 1;
        end else begin
          e.res = {int2bcd8(ai % bi), int2bcd8(ai / bi)}; e.st = 1'b0;
        end
      end
    endcase
    return e;
  endfunction

  // Issue one operation, then wait (bounded) for done and score it.
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input exp_t e, input bit immediate, input bit poke, input string name);
    exp_t        got;
    logic [15:0] prev;
    int          lat;
    bit          seen;
    bit          both;
    if (!immediate) @(negedge clk);
    prev  = result;
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = ~o; a = 8'h99; b = 8'h00;
    check({name, "_busy"}, 32'(busy), 32'(1));
    seen = 1'b0;
    both = 1'b0;
    for (lat = 1; lat <= 40; lat++) begin
      if (poke && lat == 5) begin
        start = 1'b1; op = 2'b00; a = 8'h11; b = 8'h22;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (busy && done) both = 1'b1;
      if (lat == 1 && !done) check({name, "_hold"}, 32'(result), 32'(prev));
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    got = sb_q.pop_front();
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 40 cycles, expected latency %0d", name, got.lat);
    end else begin
      check({name, "_lat"}, 32'(lat), 32'(got.lat));
      if (got.chk_val) begin
        check({name, "_res"}, 32'(result), 32'(got.res));
        check({name, "_st"}, 32'(status), 32'(got.st));
      end
      check({name, "_excl"}, 32'(both), 32'(0));
    end
  endtask

  vec_t vecs[15];

  initial begin
    exp_t e;
    int   n_done;
    logic [1:0] ro;
    logic [7:0] ra, rb;

    vecs[0]  = '{2'b00, 8'h47, 8'h68, 16'h0015, 1'b1, 2};
    vecs[1]  = '{2'b00, 8'h12, 8'h34, 16'h0046, 1'b0, 2};
    vecs[2]  = '{2'b01, 8'h25, 8'h70, 16'h0045, 1'b1, 2};
    vecs[3]  = '{2'b01, 8'h70, 8'h25, 16'h0045, 1'b0, 2};
    vecs[4]  = '{2'b01, 8'h33, 8'h33, 16'h0000, 1'b0, 2};
    vecs[5]  = '{2'b00, 8'h99, 8'h99, 16'h0098, 1'b1, 2};
    vecs[6]  = '{2'b10, 8'h99, 8'h99, 16'h9801, 1'b1, 22};
    vecs[7]  = '{2'b10, 8'h12, 8'h05, 16'h0060, 1'b0, 22};
    vecs[8]  = '{2'b10, 8'h00, 8'h57, 16'h0000, 1'b0, 22};
    vecs[9]  = '{2'b10, 8'h10, 8'h10, 16'h0100, 1'b1, 22};
    vecs[10] = '{2'b11, 8'h97, 8'h08, 16'h0112, 1'b0, 22};
    vecs[11] = '{2'b11, 8'h42, 8'h00, 16'hFFFF, 1'b1, 1};
    vecs[12] = '{2'b11, 8'h05, 8'h07, 16'h0500, 1'b0, 22};
    vecs[13] = '{2'b11, 8'h99, 8'h01, 16'h0099, 1'b0, 22};
    vecs[14] = '{2'b10, 8'h09, 8'h10, 16'h0090, 1'b0, 22};

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_status", 32'(status), 32'(0));

    foreach (vecs[i]) begin
      e.res = vecs[i].res; e.st = vecs[i].st; e.lat = vecs[i].lat; e.chk_val = 1'b1;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_op(ro, ra, rb, model(ro, ra, rb), 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    // Start pulsed mid-multiply must not disturb the operation in flight.
    run_op(2'b10, 8'h12, 8'h05, model(2'b10, 8'h12, 8'h05), 1'b0, 1'b1, "mul_poke");

    // Abort a multiply with reset at cycle 10; no done may follow.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 8'h99; b = 8'h99;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 3) begin
        start = 1'b1; op = 2'b00; a = 8'h01; b = 8'h01;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_result", 32'(result), 32'(0));
    check("abort_status", 32'(status), 32'(0));

    // Reset and start together: reset wins.
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 8'h12; b = 8'h34;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'(0));
    n_done = 0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'(0));

    // Back-to-back: second add issued in the cycle done is high.
    run_op(2'b00, 8'h12, 8'h34, model(2'b00, 8'h12, 8'h34), 1'b0, 1'b0, "b2b_first");
    run_op(2'b00, 8'h47, 8'h68, model(2'b00, 8'h47, 8'h68), 1'b1, 1'b0, "b2b_second");

`ifdef BCD_ALU_SEQ_INPUT_CHECK_EN
    e.res = 16'hFFFF; e.st = 1'b1; e.lat = 1; e.chk_val = 1'b1;
`else
    e.res = 16'h0000; e.st = 1'b0; e.lat = 2; e.chk_val = 1'b0;
`endif
    run_op(2'b00, 8'h3A, 8'h00, e, 1'b0, 1'b0, "non_bcd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
